// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream serializer.
// Holds the FSM state encoding and the bit-counter width helper.
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    function automatic int unsigned piso_idx_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register that parks the next word while the shifter is busy.
// A write wins over a read in the same cycle, so the entry stays full with the new word.
module piso_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;
    logic             full_d;

    always_comb begin
        full_d = full_q;
        if (wr) begin
            full_d = 1'b1;
        end else if (rd) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wr) begin
                data_q <= din;
            end
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer with a valid/ready word input, one-word holding
// buffer and bit-rate enable; consecutive words leave back-to-back with no idle bit.
module piso_stream
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             sout_last,
    output logic             busy
);

    localparam int unsigned     IdxW    = piso_idx_w(WIDTH);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             sout_q, sout_d;

    logic             acc;
    logic             at_last;
    logic             load_evt;
    logic             load_hold;
    logic             load_direct;
    logic             hold_wr;
    logic             hold_full;
    logic [WIDTH-1:0] hold_dout;

    // Bit presented on the line for a given shifter image.
    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[WIDTH-1];
        end
        return w[0];
    endfunction

    assign in_ready    = !hold_full;
    assign acc         = in_valid && in_ready;
    assign at_last     = (idx_q == IdxLast);
    assign load_evt    = (state_q == IDLE) || ((state_q == SHIFT) && ser_en && at_last);
    assign load_hold   = load_evt && hold_full;
    assign load_direct = load_evt && !hold_full && acc;
    // A word that goes straight into the shifter must not also be parked.
    assign hold_wr     = acc && !load_direct;

    piso_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (hold_wr),
        .rd    (load_hold),
        .din   (in_data),
        .dout  (hold_dout),
        .full  (hold_full)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        if (load_hold || load_direct) begin
            sh_d    = load_hold ? hold_dout : in_data;
            idx_d   = '0;
            state_d = SHIFT;
        end else if (load_evt) begin
            // Either idle with nothing offered, or the last bit left with no follow-up word.
            state_d = IDLE;
        end else if ((state_q == SHIFT) && ser_en) begin
            if (MSB_FIRST) begin
                sh_d = {sh_q[WIDTH-2:0], 1'b0};
            end else begin
                sh_d = {1'b0, sh_q[WIDTH-1:1]};
            end
            idx_d = idx_q + 1'b1;
        end
        sout_d = (state_d == SHIFT) ? out_bit(sh_d) : IDLE_LEVEL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            sout_q  <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            sout_q  <= sout_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = (state_q == SHIFT);
    assign sout_first = sout_valid && (idx_q == '0);
    assign sout_last  = sout_valid && at_last;
    assign busy       = (state_q == SHIFT) || hold_full;

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: an MSB-first and an LSB-first 4-bit instance share one stimulus
// and are compared every cycle against a queue-based model of words in flight.
module tb_piso_stream;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_data;
    logic       in_valid;
    logic       ser_en;

    logic m_in_ready, m_sout, m_sout_valid, m_sout_first, m_sout_last, m_busy;
    logic l_in_ready, l_sout, l_sout_valid, l_sout_first, l_sout_last, l_busy;

    piso_stream #(
        .WIDTH      (4),
        .MSB_FIRST  (1'b1),
        .IDLE_LEVEL (1'b0)
    ) u_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (m_in_ready),
        .ser_en     (ser_en),
        .sout       (m_sout),
        .sout_valid (m_sout_valid),
        .sout_first (m_sout_first),
        .sout_last  (m_sout_last),
        .busy       (m_busy)
    );

    piso_stream #(
        .WIDTH      (4),
        .MSB_FIRST  (1'b0),
        .IDLE_LEVEL (1'b1)
    ) u_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (l_in_ready),
        .ser_en     (ser_en),
        .sout       (l_sout),
        .sout_valid (l_sout_valid),
        .sout_first (l_sout_first),
        .sout_last  (l_sout_last),
        .busy       (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Model: q[0] is the word on the line, q[1] the parked word; pos counts sent bits.
    logic [3:0] q[$];
    int         pos = 0;
    logic [3:0] pend[$];
    int         ser_cnt = 0;
    bit         capture = 0;
    logic [7:0] cap = '0;
    int         ncap = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_edge();
        bit acc;
        if (!rst_n) begin
            q.delete();
            pos = 0;
            return;
        end
        acc = in_valid && (q.size() < 2);
        if (q.size() == 0) begin
            if (acc) begin
                q.push_back(in_data);
                pos = 0;
            end
        end else if (ser_en && pos == 3) begin
            void'(q.pop_front());
            if (acc) q.push_back(in_data);
            pos = 0;
        end else begin
            if (ser_en) pos = pos + 1;
            if (acc) q.push_back(in_data);
        end
        if (acc) void'(pend.pop_front());
    endtask

    task automatic check_all();
        bit         act;
        logic [3:0] w;
        act = (q.size() > 0);
        w   = act ? q[0] : 4'h0;
        chk("msb.sout",       8'(m_sout),       act ? 8'(w[3-pos]) : 8'h0);
        chk("lsb.sout",       8'(l_sout),       act ? 8'(w[pos])   : 8'h1);
        chk("msb.sout_valid", 8'(m_sout_valid), 8'(act));
        chk("lsb.sout_valid", 8'(l_sout_valid), 8'(act));
        chk("msb.sout_first", 8'(m_sout_first), 8'(act && pos == 0));
        chk("lsb.sout_first", 8'(l_sout_first), 8'(act && pos == 0));
        chk("msb.sout_last",  8'(m_sout_last),  8'(act && pos == 3));
        chk("lsb.sout_last",  8'(l_sout_last),  8'(act && pos == 3));
        chk("msb.busy",       8'(m_busy),       8'(act));
        chk("lsb.busy",       8'(l_busy),       8'(act));
        chk("msb.in_ready",   8'(m_in_ready),   8'(q.size() < 2));
        chk("lsb.in_ready",   8'(l_in_ready),   8'(q.size() < 2));
    endtask

    // ser_mode: 0 always enabled, 1 every third cycle, 2 random. gaps randomly drops in_valid.
    // in_data carries junk whenever the word would not be accepted.
    task automatic run(input int n, input int ser_mode, input bit gaps);
        for (int i = 0; i < n; i++) begin
            in_valid = (pend.size() > 0) && (!gaps || $urandom_range(0, 2) != 0);
            in_data  = (in_valid && q.size() < 2) ? pend[0] : 4'($urandom);
            case (ser_mode)
                0:       ser_en = 1'b1;
                1:       ser_en = (ser_cnt % 3 == 2);
                default: ser_en = 1'($urandom_range(0, 1));
            endcase
            ser_cnt = ser_cnt + 1;
            if (capture && m_sout_valid && ser_en) begin
                cap  = {cap[6:0], m_sout};
                ncap = ncap + 1;
            end
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        ser_en   = 1'b0;
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single word, line always enabled.
        pend.push_back(4'b1010);
        run(7, 0, 0);

        // Back-to-back pair must leave as eight consecutive bits.
        pend.push_back(4'b1101);
        pend.push_back(4'b1001);
        capture = 1;
        run(9, 0, 0);
        capture = 0;
        chk("b2b.bit_count", 8'(ncap), 8'd8);
        chk("b2b.bits", cap, 8'b1101_1001);
        run(3, 0, 0);

        // Bit-rate enable every third cycle.
        pend.push_back(4'b1010);
        ser_cnt = 0;
        run(16, 1, 0);

        // Backpressure: valid held with junk data while the buffer is full.
        pend.push_back(4'b0110);
        pend.push_back(4'b1011);
        pend.push_back(4'b0011);
        ser_cnt = 0;
        run(45, 1, 0);

        // Asynchronous reset in the middle of a word, with a second word parked.
        pend.push_back(4'b1110);
        pend.push_back(4'b0101);
        run(3, 0, 0);
        #2;
        rst_n = 1'b0;
        pend.delete();
        q.delete();
        pos = 0;
        #1;
        check_all();
        run(2, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(4, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) pend.push_back(4'($urandom));
        run(350, 2, 1);
        run(40, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out serializer with a valid/ready parallel input, a one-word holding buffer and a bit-rate enable. It is the next generation of the 4-bit load/shift PISO. The handshake replaces the `mode` strobe, and the holding buffer lets consecutive words leave back-to-back with no idle bit between them. It sits between a word-oriented producer and a serial line driver.

## Interface
- `WIDTH`, 8, word width in bits (≥ 2)
- `MSB_FIRST`, 1, 1 = bit WIDTH-1 sent first, 0 = bit 0 first
- `IDLE_LEVEL`, 0, value driven on `sout` when no bit is being presented
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `in_data`  in  WIDTH  parallel word
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block can accept a word this cycle
- `ser_en`  in  1  line consumes the presented bit this cycle
- `sout`  out  1  serial bit, registered
- `sout_valid`  out  1  `sout` carries a data bit
- `sout_first`  out  1  presented bit is bit 0 of a word (in send order)
- `sout_last`  out  1  presented bit is bit WIDTH-1 of a word (in send order)
- `busy`  out  1  shifter active or holding buffer full

## Operation
- **Storage:** shift register `sh[WIDTH-1:0]`, bit counter `idx` (0..WIDTH-1), holding register `hold` with flag `hold_full`.
- **State machine:** `IDLE`, `SHIFT`.
- **Accept:** `acc = in_valid && in_ready`. `in_ready = !hold_full` (combinational).
- **Load event:** occurs in `IDLE`, or in `SHIFT` when `ser_en && idx == WIDTH-1`.
  - If `hold_full`, the shifter loads from `hold`.
  - Otherwise, if `acc`, the shifter loads directly from `in_data`.
  - In both cases `idx` is cleared, state becomes `SHIFT`, and the first bit is presented in the next cycle.
- **Holding buffer:**
  - `acc` writes `in_data` into `hold` unless that word went straight to the shifter.
  - A load from `hold` in the same cycle as `acc` leaves `hold_full` set, now holding the new word.
  - A load from `hold` without `acc` clears `hold_full`.
- **Bit progression:** in `SHIFT` with `ser_en` and `idx < WIDTH-1`, shift one position (toward MSB-out or LSB-out per `MSB_FIRST`) and increment `idx`. Without `ser_en`, all state and outputs hold.
- **End of word:** in `SHIFT` with `ser_en`, `idx == WIDTH-1` and no word available, state goes to `IDLE`. In the next cycle `sout = IDLE_LEVEL` and `sout_valid = 0`.
- **Output flags:** `sout_first = sout_valid && idx == 0`. `sout_last = sout_valid && idx == WIDTH-1`.
- **Busy:** `busy = (state == SHIFT) || hold_full`.

## Timing
- **Reset values:** `sout = IDLE_LEVEL`; `sout_valid`, `sout_first`, `sout_last`, `busy` = 0; `hold_full = 0`, so `in_ready = 1`; state `IDLE`.
- **Reset mid-word:** abandons the word immediately (asynchronous). Both words are lost; nothing is resumed.
- **Latency:** a word accepted at edge N in `IDLE` presents its first bit after edge N; `sout_valid = 1` in cycle N+1, independent of `ser_en`.
- **Word duration:** each bit is presented until a cycle with `ser_en = 1`. A word needs exactly WIDTH `ser_en` cycles.
- **Gapless streaming:** with `hold_full` at the last-bit `ser_en`, the next word's first bit appears in the following cycle.
- **Simultaneous events:**
  - Holding buffer full with `in_valid` high: no accept; `in_data` is ignored.
  - Load and accept in the same cycle: allowed, handled as described under Operation.
- **Throughput:** sustained one word per WIDTH `ser_en` cycles. At most two words are in flight (shifter plus `hold`).

## Structure
- Package `piso_pkg`: `piso_state_e` {`IDLE`, `SHIFT`}, and a function `piso_idx_w(WIDTH) = $clog2(WIDTH)`.
- One sub-module: `piso_hold_buf`, a one-entry register with `wr`, `rd`, `din`, `dout`, `full`, with write and read allowed in the same cycle.
- The top level contains the FSM, shifter and counter.

## Test plan
- **Reset:** drive `rst_n = 0` mid-word with WIDTH=4 -> `sout = IDLE_LEVEL`, `sout_valid = 0`, `in_ready = 1` within the same cycle. After release the block stays idle.
- **Single word:** WIDTH=4, MSB_FIRST=1, accept `4'b1010`, `ser_en = 1` constantly -> `sout` 1,0,1,0 over cycles N+1..N+4. `sout_first` is high only in N+1 and `sout_last` only in N+4; `sout_valid` drops in N+5.
- **LSB-first:** MSB_FIRST=0, accept `4'b1101` -> `sout` 1,0,1,1.
- **Back-to-back:** offer `4'b1101` then `4'b1001` with `in_valid` held -> the second word is accepted into `hold`, then `in_ready = 0` until the first word's last bit. Output is 1,1,0,1,1,0,0,1 with no gap.
- **Bit-rate enable:** `ser_en` high every third cycle with `4'b1010` -> each bit is held exactly 3 cycles. `sout_valid` stays high throughout; total 12 cycles.
- **Backpressure:** hold the shifter busy and `hold` full with `in_valid = 1` and changing `in_data` -> no accept and no corruption. The buffered word is sent intact.
